stw_sequencer: RTL
==================

# stw_sequencer

Self-test-while-working (STW) sequencer for a row of `NUM_PE` MAC processing elements. It sits directly upstream and downstream of the PEs' STW ports:
- it builds a test vector and its expected result, broadcasts them, and pulses start in a gap the array controller grants;
- it collects every PE's complete/result bits and keeps a sticky per-PE fault map that the BISR remap logic reads.

## Interface
Parameters:
- `WORD_SIZE`, 16: PE operand width; legal range 8..32.
- `NUM_PE`, 4: number of PEs served; range 1..32.
- `PERIOD`, 1024: cycles between automatic test requests; minimum 8.
- `TIMEOUT`, 8: WAIT-state cycle limit before non-completing PEs are declared faulty.
- `SEED`, 32'hACE1_0001: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: enables the periodic request counter.
- `manual_req`, in, 1: one-cycle pulse that requests a test immediately.
- `vec_sel`, in, 1: vector source. 0 = LFSR; 1 = `cfg_op1`/`cfg_op2`/`cfg_add`.
- `cfg_op1`, `cfg_op2`, `cfg_add`, in, WORD_SIZE each: fixed vector operands.
- `gap_ok`, in, 1: the array controller guarantees that PE `left_in`/`top_in` stay stable this cycle and the next three cycles.
- `clear_map`, in, 1: clears `fault_map`.
- `stw_load_en`, out, 1: broadcast to PE `STW_test_load_en`.
- `stw_op1`, `stw_op2`, `stw_add`, `stw_expected`, out, WORD_SIZE each: broadcast vector.
- `stw_start`, out, 1: broadcast to PE `STW_start`.
- `stw_complete`, in, NUM_PE: bit i comes from PE i `STW_complete`.
- `stw_result`, in, NUM_PE: bit i comes from PE i `STW_result_out`; 1 = pass.
- `busy`, out, 1: high in every state except IDLE.
- `fault_map`, out, NUM_PE: sticky bit per PE; 1 = faulty.
- `fault_irq`, out, 1: one-cycle pulse when any `fault_map` bit newly sets.
- `test_count`, out, 16: completed tests, wraps at 16'hFFFF to 0.

## Operation
**Request logic**
- A period counter counts while `en` = 1. At `PERIOD-1` it wraps to 0 and sets `pending`.
- `manual_req` also sets `pending`.
- `pending` clears on the IDLE->LOAD transition.
- Requests arriving while `pending` is already set merge into it.

**FSM states: IDLE, LOAD, START, WAIT, CHECK.**
- IDLE -> LOAD when `pending` && `gap_ok`.
  - On this edge, register the operands: from the LFSR when `vec_sel`=0, otherwise from the cfg inputs.
  - LFSR mapping: op1 = lfsr[WORD_SIZE-1:0]; op2 = lfsr[31:32-WORD_SIZE]; add = op1 ^ op2.
  - Register `stw_expected` = (op1*op2 + add) mod 2^WORD_SIZE.
- LOAD: `stw_load_en`=1 for exactly one cycle; always -> START.
- START: `stw_start`=1 for exactly one cycle; always -> WAIT; clear the timeout counter.
- WAIT:
  - -> CHECK when all `stw_complete` bits = 1 and the wait counter ≥ 1. The first WAIT cycle is ignored because PEs drop complete on the start edge.
  - -> CHECK when the counter reaches `TIMEOUT-1`.
- CHECK: one cycle, then -> IDLE.
  - Set `fault_map[i]` for every PE with `stw_complete[i]`=0 or `stw_result[i]`=0.
  - Increment `test_count`.
  - Pulse `fault_irq` if any bit went 0->1.

**LFSR**
- 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps 0x80200003).
- Advances once per IDLE->LOAD transition, after the sample.

**Fault map rules**
- `fault_map` is sticky; only `rst` or `clear_map` clears it.
- If `clear_map` and a CHECK set occur in the same cycle, the set wins for the bits it sets; all other bits clear.
- `en`=0 freezes the period counter. An in-flight test always runs to completion.

## Timing
- Reset values: `stw_load_en`=0, `stw_start`=0, `busy`=0, `fault_map`=0, `fault_irq`=0, `test_count`=0, vector outputs=0, LFSR=`SEED`, period counter=0, `pending`=0, state=IDLE.
- Vector outputs are registered and held stable from LOAD until the next IDLE->LOAD.
- Fault-free PEs: grant edge → LOAD (cycle 1) → START (cycle 2) → WAIT (cycles 3-4) → CHECK (cycle 5). `fault_map`/`fault_irq` become valid at cycle 6.
- `gap_ok` need only be high on the grant cycle. The gap guarantee covers the START/WAIT window.
- `rst` mid-test: immediate return to IDLE with all outputs at reset values. The aborted test is not counted.

## Test plan
- **Fixed vector, all pass:** `vec_sel`=1; op1=3, op2=5, add=7; `manual_req`; `gap_ok`=1; PE models complete 2 cycles after start with result 1.
  - Required: `stw_expected`=22, one `stw_load_en` then one `stw_start` pulse, `fault_map`=0, `test_count`=1, no irq.
- **Single fault:** same stimulus with PE2 result 0.
  - Required: `fault_map`=4'b0100 and one `fault_irq` pulse.
  - Repeat with PE2 still failing: map unchanged, no second irq.
- **Timeout:** PE0 never raises complete, `TIMEOUT`=8.
  - Required: CHECK is reached 8 cycles after entering WAIT and `fault_map[0]`=1.
- **Width wrap:** op1=16'hFFFF, op2=2, add=3.
  - Required: `stw_expected`=16'h0001.
- **Gating/periodic:** `PERIOD`=8, `en`=1, `gap_ok` low for 20 cycles then high.
  - Required: exactly one test starts on the first `gap_ok` cycle; multiple expirations merge into it.
- **Reset mid-WAIT and clear/set collision:** assert `rst` in WAIT.
  - Required: all outputs return to reset values.
  - Separately, `clear_map` with map=4'b0011 in the same cycle CHECK flags PE3: map=4'b1000.

Source files
------------

// File: rtl/stw_sequencer_if.sv
// STW broadcast/collect bundle between the sequencer and a row of MAC PEs.
interface stw_sequencer_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE    = 4
);
  logic                 stw_load_en;
  logic [WORD_SIZE-1:0] stw_op1;
  logic [WORD_SIZE-1:0] stw_op2;
  logic [WORD_SIZE-1:0] stw_add;
  logic [WORD_SIZE-1:0] stw_expected;
  logic                 stw_start;
  logic [NUM_PE-1:0]    stw_complete;
  logic [NUM_PE-1:0]    stw_result;

  modport master (
    output stw_load_en, stw_op1, stw_op2, stw_add, stw_expected, stw_start,
    input  stw_complete, stw_result
  );

  modport slave (
    input  stw_load_en, stw_op1, stw_op2, stw_add, stw_expected, stw_start,
    output stw_complete, stw_result
  );
endinterface

// File: rtl/stw_sequencer.sv
// Self-test-while-working sequencer: launches a MAC test vector into idle gaps
// and folds per-PE pass/complete bits into a sticky fault map.
module stw_sequencer #(
  parameter int          WORD_SIZE = 16,
  parameter int          NUM_PE    = 4,
  parameter int          PERIOD    = 1024,
  parameter int          TIMEOUT   = 8,
  parameter logic [31:0] SEED      = 32'hACE1_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 manual_req,
  input  logic                 vec_sel,
  input  logic [WORD_SIZE-1:0] cfg_op1,
  input  logic [WORD_SIZE-1:0] cfg_op2,
  input  logic [WORD_SIZE-1:0] cfg_add,
  input  logic                 gap_ok,
  input  logic                 clear_map,
  stw_sequencer_if.master      bus,
  output logic                 busy,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 fault_irq,
  output logic [15:0]          test_count
);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        period_cnt;
  logic [TW-1:0]        wait_cnt;
  logic                 pending;
  logic [31:0]          lfsr;
  logic                 grant, check;
  logic                 period_wrap;
  logic [WORD_SIZE-1:0] op1_q, op2_q, add_q, exp_q;
  logic [WORD_SIZE-1:0] sel_op1, sel_op2, sel_add, sel_prod;
  logic [NUM_PE-1:0]    new_fail;

  assign period_wrap = en && (period_cnt == PW'(PERIOD - 1));

  always_comb begin
    state_d         = state_q;
    bus.stw_load_en = 1'b0;
    bus.stw_start   = 1'b0;
    busy            = 1'b1;
    grant           = 1'b0;
    check           = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pending && gap_ok) begin
          grant   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.stw_load_en = 1'b1;
        state_d         = S_START;
      end
      S_START: begin
        bus.stw_start = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        // PEs drop complete on the start edge, so the first WAIT cycle is stale.
        if (((&bus.stw_complete) && (wait_cnt != '0)) || (wait_cnt == TW'(TIMEOUT - 1)))
          state_d = S_CHECK;
      end
      S_CHECK: begin
        check   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      pending    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (en) period_cnt <= period_wrap ? '0 : period_cnt + 1'b1;
      // A request landing on the grant cycle merges into the test being launched.
      pending <= (pending | manual_req | period_wrap) & ~grant;
      if (state_q == S_START)     wait_cnt <= '0;
      else if (state_q == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign sel_op1  = vec_sel ? cfg_op1 : lfsr[WORD_SIZE-1:0];
  assign sel_op2  = vec_sel ? cfg_op2 : lfsr[31:32-WORD_SIZE];
  assign sel_add  = vec_sel ? cfg_add : (lfsr[WORD_SIZE-1:0] ^ lfsr[31:32-WORD_SIZE]);
  assign sel_prod = sel_op1 * sel_op2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= SEED;
      op1_q <= '0;
      op2_q <= '0;
      add_q <= '0;
      exp_q <= '0;
    end else if (grant) begin
      lfsr  <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      op1_q <= sel_op1;
      op2_q <= sel_op2;
      add_q <= sel_add;
      exp_q <= sel_prod + sel_add;
    end
  end

  assign bus.stw_op1      = op1_q;
  assign bus.stw_op2      = op2_q;
  assign bus.stw_add      = add_q;
  assign bus.stw_expected = exp_q;

  assign new_fail = check ? (~bus.stw_complete | ~bus.stw_result) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_map  <= '0;
      fault_irq  <= 1'b0;
      test_count <= '0;
    end else begin
      fault_map  <= clear_map ? new_fail : (fault_map | new_fail);
      fault_irq  <= |(new_fail & ~fault_map);
      if (check) test_count <= test_count + 16'd1;
    end
  end
endmodule
